// File: rtl/store_writeback_unit.sv
// store_writeback_unit
//   Drains committed, address-resolved stores from the store data queue (SDQ)
//   to the data memory port in program order. Stores are buffered in a small
//   FIFO. Memory writes use a req/gnt/ack handshake, one store at a time. Each
//   completed write returns a one-cycle clear pulse so the SDQ can release the
//   matching entry. SDQ entries stay forwardable until memory has acked.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   issue_en_o             SDQ may pop a committed store this cycle
//   issue_vld_i            registered SDQ output valid (1 cycle after issue_en_o)
//   issue_entry_i          issued SDQ entry (addr, store_data)
//   mem_req_o              write request, held with addr/wdata until grant
//   mem_addr_o             word-aligned write address
//   mem_wdata_o            write data
//   mem_gnt_i, mem_ack_i   memory accepted request / write completed
//   clear_sdq_ent_vld_o    one-cycle pulse releasing an SDQ entry
//   clear_sdq_ent_idx_o    index of the released SDQ entry
//   wb_empty_o             buffer empty and FSM idle (fence/drain)
//   misalign_o             sticky: a store with addr[1:0] != 0 was received

typedef struct packed {
  logic [31:0] addr;
  logic [31:0] store_data;
} sdq_entry_t;

module store_writeback_unit #(
  parameter int unsigned WB_ENTRIES  = 4,
  parameter int unsigned SDQ_ENTRIES = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  output logic                           issue_en_o,
  input  logic                           issue_vld_i,
  input  sdq_entry_t                     issue_entry_i,
  output logic                           mem_req_o,
  output logic [31:0]                    mem_addr_o,
  output logic [31:0]                    mem_wdata_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_ack_i,
  output logic                           clear_sdq_ent_vld_o,
  output logic [$clog2(SDQ_ENTRIES)-1:0] clear_sdq_ent_idx_o,
  output logic                           wb_empty_o,
  output logic                           misalign_o
);

  localparam int unsigned PtrW = $clog2(WB_ENTRIES);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = $clog2(SDQ_ENTRIES);

  // Issue only while two slots are free: one for this pop, one for the store
  // already in flight through the registered SDQ output.
  localparam logic [CntW-1:0] IssueMax = CntW'(WB_ENTRIES - 2);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(SDQ_ENTRIES - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StWaitAck = 2'd2;

  // Buffer storage; only the word address is kept.
  logic [29:0]     buf_addr_q [WB_ENTRIES];
  logic [31:0]     buf_data_q [WB_ENTRIES];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] clr_ptr_q, clr_idx_q;
  logic            clr_vld_q;
  logic            misalign_q;
  logic            rdy_q;
  logic            push, pop;

  assign push = issue_vld_i;

  // A write completes on ack in WAIT_ACK, or on gnt+ack together in REQ.
  assign pop = mem_ack_i && ((state_q == StWaitAck) || ((state_q == StReq) && mem_gnt_i));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (!push && pop) begin
      count_d = count_q - CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StReq;
      end
      StReq: begin
        if (pop) begin
          state_d = (count_d != '0) ? StReq : StIdle;
        end else if (mem_gnt_i) begin
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (pop) state_d = (count_d != '0) ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      clr_ptr_q  <= '0;
      clr_idx_q  <= '0;
      clr_vld_q  <= 1'b0;
      misalign_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      state_q   <= state_d;
      count_q   <= count_d;
      clr_vld_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        clr_idx_q <= clr_ptr_q;
        clr_ptr_q <= (clr_ptr_q == IdxLast) ? '0 : clr_ptr_q + 1'b1;
      end
      if (push && (issue_entry_i.addr[1:0] != 2'b00)) misalign_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= issue_entry_i.addr[31:2];
      buf_data_q[wr_ptr_q] <= issue_entry_i.store_data;
    end
  end

  assign issue_en_o          = rdy_q && (count_q <= IssueMax);
  assign mem_req_o           = (state_q == StReq);
  // Zeroed outside REQ so the port is quiet during reset and idle.
  assign mem_addr_o          = mem_req_o ? {buf_addr_q[rd_ptr_q], 2'b00} : '0;
  assign mem_wdata_o         = mem_req_o ? buf_data_q[rd_ptr_q] : '0;
  assign clear_sdq_ent_vld_o = clr_vld_q;
  assign clear_sdq_ent_idx_o = clr_idx_q;
  assign wb_empty_o          = (count_q == '0) && (state_q == StIdle);
  assign misalign_o          = misalign_q;

endmodule

// File: tb/tb_store_writeback_unit.sv
module tb_store_writeback_unit;

  localparam int WbEntries  = 4;
  localparam int SdqEntries = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_en;
  logic        issue_vld = 1'b0;
  logic [63:0] issue_entry = '0;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_ack = 1'b0;
  logic        clr_vld;
  logic [2:0]  clr_idx;
  logic        wb_empty;
  logic        misalign;

  store_writeback_unit #(
    .WB_ENTRIES (WbEntries),
    .SDQ_ENTRIES(SdqEntries)
  ) u_dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .issue_en_o         (issue_en),
    .issue_vld_i        (issue_vld),
    .issue_entry_i      (issue_entry),
    .mem_req_o          (mem_req),
    .mem_addr_o         (mem_addr),
    .mem_wdata_o        (mem_wdata),
    .mem_gnt_i          (mem_gnt),
    .mem_ack_i          (mem_ack),
    .clear_sdq_ent_vld_o(clr_vld),
    .clear_sdq_ent_idx_o(clr_idx),
    .wb_empty_o         (wb_empty),
    .misalign_o         (misalign)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // SDQ model: stores waiting to be issued, in program order.
  logic [63:0] pending[$];
  // Scoreboard: expected {aligned addr, data} in write order, and clear indices.
  logic [63:0] exp_st[$];
  int          exp_clr[$];

  int          tb_cnt;
  bit          prev_en;
  int          clr_ptr_m;
  bit          outstanding;
  int          ack_cnt;
  int          ack_lat;
  int          gnt_block;
  bit          push_on_ack;
  logic [63:0] held;
  bit          chk_req_next;
  bit          exp_req_val;
  int          n_clr;
  int          n_req;
  bit          saw_en_low;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit drained();
    return (pending.size() == 0) && (exp_st.size() == 0) && (exp_clr.size() == 0) &&
           !outstanding && (tb_cnt == 0);
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni    = 1'b0;
    issue_vld = 1'b0;
    mem_gnt   = 1'b0;
    mem_ack   = 1'b0;
    #1;
    check_eq("rst_issue_en", issue_en, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_clr_vld", clr_vld, 0);
    check_eq("rst_clr_idx", clr_idx, 0);
    check_eq("rst_wb_empty", wb_empty, 1);
    check_eq("rst_misalign", misalign, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    pending.delete();
    exp_st.delete();
    exp_clr.delete();
    tb_cnt       = 0;
    prev_en      = 1'b0;
    clr_ptr_m    = 0;
    outstanding  = 1'b0;
    ack_cnt      = 0;
    gnt_block    = 0;
    push_on_ack  = 1'b0;
    chk_req_next = 1'b0;
    n_clr        = 0;
    n_req        = 0;
    saw_en_low   = 1'b0;
  endtask

  // One clock: sample at negedge, check, then drive next inputs.
  task automatic step();
    logic [63:0] e;
    logic [63:0] st;
    bit          ack_now;
    bit          pushed;
    int          cnt_next;
    @(negedge clk_i);
    ack_now = 1'b0;
    pushed  = 1'b0;

    check_eq("issue_en", issue_en, (tb_cnt <= WbEntries - 2) ? 1 : 0);
    if (!issue_en) saw_en_low = 1'b1;
    if (mem_req) n_req++;

    if (chk_req_next) begin
      check_eq("req_after_ack", mem_req, exp_req_val);
      check_eq("empty_after_ack", wb_empty, !exp_req_val);
      chk_req_next = 1'b0;
    end

    if (exp_clr.size() > 0) begin
      check_eq("clr_vld", clr_vld, 1);
      if (clr_vld) begin
        check_eq("clr_idx", clr_idx, 64'(exp_clr.pop_front()));
        n_clr++;
      end else begin
        void'(exp_clr.pop_front());
      end
    end else if (clr_vld) begin
      check_eq("clr_spurious", clr_vld, 0);
      n_clr++;
    end

    // Memory model.
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
    if (outstanding) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        mem_ack     = 1'b1;
        ack_now     = 1'b1;
        outstanding = 1'b0;
      end
    end else if (mem_req) begin
      if (exp_st.size() == 0) begin
        check_eq("req_unexpected", mem_req, 0);
      end else begin
        st = exp_st[0];
        check_eq("mem_addr", mem_addr, st[63:32]);
        check_eq("mem_wdata", mem_wdata, st[31:0]);
      end
      if (gnt_block > 0) begin
        gnt_block--;
      end else begin
        mem_gnt = 1'b1;
        if (exp_st.size() > 0) void'(exp_st.pop_front());
        if (ack_lat == 0) begin
          mem_ack = 1'b1;
          ack_now = 1'b1;
        end else begin
          outstanding = 1'b1;
          ack_cnt     = ack_lat;
        end
      end
    end
    if (ack_now) begin
      exp_clr.push_back(clr_ptr_m);
      clr_ptr_m = (clr_ptr_m + 1) % SdqEntries;
      if (push_on_ack) begin
        pending.push_back(held);
        push_on_ack = 1'b0;
      end
    end

    // SDQ model: registered issue, one cycle behind issue_en.
    issue_vld = 1'b0;
    if (prev_en && (pending.size() > 0)) begin
      e           = pending.pop_front();
      issue_vld   = 1'b1;
      issue_entry = e;
      exp_st.push_back({e[63:34], 2'b00, e[31:0]});
      pushed = 1'b1;
    end
    prev_en = issue_en;

    cnt_next = tb_cnt + (pushed ? 1 : 0) - (ack_now ? 1 : 0);
    if (pushed) check_eq("no_overflow", (cnt_next <= WbEntries) ? 1 : 0, 1);
    if (ack_now) begin
      chk_req_next = 1'b1;
      exp_req_val  = (cnt_next > 0);
    end
    tb_cnt = cnt_next;
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n = 0;
    while (!drained() && (n < budget)) begin
      step();
      n++;
    end
    check_eq({tag, "_drained"}, drained(), 1);
    check_eq({tag, "_wb_empty"}, wb_empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: single store, ack two cycles after grant.
    do_reset();
    ack_lat = 2;
    pending.push_back({32'h0000_0100, 32'hDEAD_BEEF});
    run_drain("t1", 40);
    check_eq("t1_req_cycles", n_req, 1);
    check_eq("t1_clr_count", n_clr, 1);
    check_eq("t1_misalign", misalign, 0);

    // 2: four stores with grant held off; buffer fills without overflow.
    do_reset();
    ack_lat   = 1;
    gnt_block = 10;
    for (int i = 0; i < 4; i++) pending.push_back({32'h0000_2000 + 32'(i * 4), 32'hA000_0000 + 32'(i)});
    run_drain("t2", 80);
    check_eq("t2_en_dropped", saw_en_low, 1);
    check_eq("t2_clr_count", n_clr, 4);

    // 3: ten stores, clear index wraps at SDQ_ENTRIES.
    do_reset();
    ack_lat = 1;
    for (int i = 0; i < 10; i++) pending.push_back({32'h0001_0000 + 32'(i * 4), $urandom()});
    run_drain("t3", 120);
    check_eq("t3_clr_count", n_clr, 10);

    // 4: push lands in the same cycle as an ack with two stores buffered.
    do_reset();
    ack_lat     = 2;
    gnt_block   = 6;
    pending.push_back({32'h0000_3000, 32'h1111_1111});
    pending.push_back({32'h0000_3004, 32'h2222_2222});
    held        = {32'h0000_3008, 32'h3333_3333};
    push_on_ack = 1'b1;
    run_drain("t4", 80);
    check_eq("t4_clr_count", n_clr, 3);

    // 5: grant and ack in the same cycle, back-to-back.
    do_reset();
    ack_lat = 0;
    for (int i = 0; i < 3; i++) pending.push_back({32'h0000_4000 + 32'(i * 4), 32'hB000_0000 + 32'(i)});
    run_drain("t5", 60);
    check_eq("t5_clr_count", n_clr, 3);

    // 6: misaligned store, reset while waiting for ack.
    do_reset();
    ack_lat = 5;
    pending.push_back({32'h0000_0103, 32'hCAFE_F00D});
    for (int i = 0; (i < 20) && !outstanding; i++) step();
    check_eq("t6_granted", outstanding, 1);
    step();
    check_eq("t6_misalign", misalign, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step();
    check_eq("t6_no_clr", n_clr, 0);
    check_eq("t6_idle_req", mem_req, 0);
    check_eq("t6_idle_empty", wb_empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
